// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter and the receive-side sync detector.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StParity,
    StGap
  } seq_state_e;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter only ever holds (max_val - 1), so $clog2(max_val) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable MSB-first shift register with a saturating down-counter for bit position.
module seq_tx_shifter #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  load_val,
  input  logic [CW-1:0] load_cnt,
  output logic          msb,
  output logic          cnt_zero
);

  logic [W-1:0]  sreg_q;
  logic [CW-1:0] cnt_q;

  // Zeros shift in, so the line idles low once a field has been fully sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= load_val;
      cnt_q  <= load_cnt;
    end else if (shift) begin
      sreg_q <= sreg_q << 1;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign msb      = sreg_q[W-1];
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, even parity, then idle gap.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEFAULT,
  parameter int unsigned       GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned SW = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned CW = cnt_width(max3(SYNC_W, DATA_W, GAP_BITS));

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  // Fields are left-aligned so the shifter MSB is always the bit on the line.
  localparam logic [SW-1:0] SYNC_LOAD = SW'(SYNC_PAT) << (SW - SYNC_W);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] payload_q;
  logic              load, shift, cnt_zero, msb;
  logic [SW-1:0]     load_val;
  logic [CW-1:0]     load_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      payload_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) payload_q <= in_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift    = 1'b0;
    load_val = '0;
    load_cnt = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d  = StSync;
          load     = 1'b1;
          load_val = SYNC_LOAD;
          load_cnt = SYNC_LAST;
        end
      end
      StSync: begin
        if (cnt_zero) begin
          state_d  = StData;
          load     = 1'b1;
          load_val = SW'(payload_q) << (SW - DATA_W);
          load_cnt = DATA_LAST;
        end else begin
          shift = 1'b1;
        end
      end
      StData: begin
        if (cnt_zero) begin
          state_d  = StParity;
          load     = 1'b1;
          load_val = SW'(^payload_q) << (SW - 1);
        end else begin
          shift = 1'b1;
        end
      end
      StParity: begin
        // Loading zeros drops the line low for the gap (or idle).
        load = 1'b1;
        if (GAP_BITS == 0) begin
          state_d = StIdle;
        end else begin
          state_d  = StGap;
          load_cnt = GAP_LAST;
        end
      end
      StGap: begin
        if (cnt_zero) state_d = StIdle;
        else          shift   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  seq_tx_shifter #(
    .W  (SW),
    .CW (CW)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .load_val (load_val),
    .load_cnt (load_cnt),
    .msb      (msb),
    .cnt_zero (cnt_zero)
  );

  assign dout       = msb;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StParity);
  assign in_ready   = (state_q == StIdle) && !reset;

endmodule
